// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported unified memory between the instruction-fetch port
// (I) and the data port (D) of a processor core. Handles one memory
// transaction at a time, with a req/ack handshake on every side.
//
// Arbitration: data wins over fetch. After MAX_D_STREAK consecutive data
// grants made while fetch was also waiting, the next contended grant goes to
// fetch so that fetch cannot be starved.
//
// Transaction sequence: IDLE (sample requests) -> GRANT (mem_req held until
// mem_ack) -> RESP (one-cycle ack to the owner) -> IDLE.
//
// Optional build macro:
//   MEM_ARB_TIMEOUT_EN  - aborts a GRANT that waits TIMEOUT cycles for
//                         mem_ack. The aborted access returns 32'hDEADBEEF
//                         on reads and pulses err. Adds the TIMEOUT
//                         parameter and the err port.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   i_req/i_addr        fetch request and address (held until i_ack)
//   i_ack/i_rdata       fetch completion pulse and fetched word
//   d_req/d_we/d_addr/d_wdata
//                       data request, direction, address, write data
//   d_ack/d_rdata       data completion pulse and read data
//   mem_req/mem_we/mem_addr/mem_wdata
//                       memory request, held until mem_ack
//   mem_rdata/mem_ack   memory read data and completion
//   err                 timeout pulse (MEM_ARB_TIMEOUT_EN only)
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int MAX_D_STREAK = 4
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT      = 255
`endif
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ack,
    output logic [DW-1:0] i_rdata,

    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,

    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    output logic          err
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t     state;
    logic       owner_d;     // 1: current transaction belongs to the data port
    logic [3:0] streak;      // consecutive data grants made while fetch waited
    logic       pick_d;      // arbitration result for this IDLE cycle

`ifdef MEM_ARB_TIMEOUT_EN
    logic [7:0] wait_cnt;
    logic       wait_expired;

    // The counter would reach TIMEOUT at the end of this GRANT cycle.
    assign wait_expired = (wait_cnt == 8'(TIMEOUT - 1));
`endif

    // Data wins unless fetch is also waiting and data has already used up
    // its streak allowance.
    assign pick_d = d_req && !(i_req && (streak == 4'(MAX_D_STREAK)));

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the values from before the clock edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: datapath registers are reset as well as control, because
            // every output must read 0 after reset, not just the handshakes.
            state     <= IDLE;
            owner_d   <= 1'b0;
            streak    <= 4'd0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_ack     <= 1'b0;
            d_ack     <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            wait_cnt  <= 8'd0;
            err       <= 1'b0;
`endif
        end else begin
            // Acks (and err) are one-cycle pulses; only the GRANT exit raises them.
            i_ack <= 1'b0;
            d_ack <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            err   <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        state   <= GRANT;
                        mem_req <= 1'b1;
                        owner_d <= pick_d;
`ifdef MEM_ARB_TIMEOUT_EN
                        wait_cnt <= 8'd0;
`endif
                        if (pick_d) begin
                            mem_we    <= d_we;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                            if (!i_req) begin
                                streak <= 4'd0;
                            end else if (streak != 4'hF) begin
                                streak <= streak + 4'd1;
                            end
                        end else begin
                            mem_we    <= 1'b0;
                            mem_addr  <= i_addr;
                            mem_wdata <= '0;
                            streak    <= 4'd0;
                        end
                    end
                end

                GRANT: begin
                    // mem_ack takes precedence over an expiring wait.
                    if (mem_ack) begin
                        state   <= RESP;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (owner_d) begin
                            d_ack <= 1'b1;
                            if (!mem_we) d_rdata <= mem_rdata;
                        end else begin
                            i_ack <= 1'b1;
                            if (!mem_we) i_rdata <= mem_rdata;
                        end
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    else if (wait_expired) begin
                        state   <= RESP;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        err     <= 1'b1;
                        if (owner_d) begin
                            d_ack <= 1'b1;
                            if (!mem_we) d_rdata <= DW'(32'hDEADBEEF);
                        end else begin
                            i_ack <= 1'b1;
                            if (!mem_we) i_rdata <= DW'(32'hDEADBEEF);
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
`endif
                end

                // The ack pulse is visible during RESP; requests are not
                // looked at until the following IDLE cycle.
                RESP: state <= IDLE;

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the processor's instruction-fetch port and data port.
- Sits between the core (instr_addr/instr_in, data_addr/data_in/data_out/data_rd_wr) and the memory model/controller.
- Sequences one memory transaction at a time with a req/ack handshake on each side.
- Fixed data-over-instruction priority, with a starvation guard for fetch.

Parameters:
- AW, 32, address width
- DW, 32, data width
- MAX_D_STREAK, 4, consecutive contended data grants allowed before fetch is forced through (1..15)
- TIMEOUT, 255, cycles to wait for mem_ack before abort (only with MEM_ARB_TIMEOUT_EN)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- i_req  in  1  fetch request, held until i_ack
- i_addr  in  AW  fetch address, stable while i_req
- i_ack  out  1  one-cycle pulse, fetch complete
- i_rdata  out  DW  fetched word, valid with i_ack, held after
- d_req  in  1  data request, held until d_ack
- d_we  in  1  1=write, 0=read, stable while d_req
- d_addr  in  AW  data address
- d_wdata  in  DW  write data
- d_ack  out  1  one-cycle pulse, data access complete
- d_rdata  out  DW  read data, valid with d_ack on reads, held after
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid with mem_ack
- mem_ack  in  1  memory completion, may arrive the same cycle mem_req first rises or any later cycle
- err  out  1  timeout pulse (present only with MEM_ARB_TIMEOUT_EN)

Behaviour:
- Reset values: all outputs 0, including mem_addr, mem_wdata, i_rdata and d_rdata. State=IDLE, owner=none, streak counter=0.
- FSM states: IDLE, GRANT, RESP.
- IDLE:
  - Samples i_req and d_req. No request: stay in IDLE.
  - Only d_req: grant D.
  - Only i_req: grant I.
  - Both asserted: grant D unless streak==MAX_D_STREAK, in which case grant I.
  - On grant: latch addr/we/wdata of the winner into mem_* registers, set mem_req=1, go to GRANT.
  - mem_we is forced 0 for I grants.
- Streak counter:
  - D grant while i_req=1: streak+1 (saturating).
  - I grant, or D grant while i_req=0: streak=0.
- GRANT:
  - mem_req stays 1 and mem_* stay stable until mem_ack.
  - On mem_ack: mem_req=0, mem_we=0. If the access was a read, register mem_rdata into the owner's rdata. Go to RESP.
- RESP:
  - Owner's ack=1 for exactly this cycle. Next state is IDLE.
  - Requests are not sampled in RESP.
  - A req still high in the following IDLE cycle is a new transaction.
- Latency:
  - req seen in IDLE at cycle 0, mem_req high at cycle 1.
  - Zero-wait mem_ack at cycle 1 gives ack at cycle 2, IDLE at cycle 3.
  - Minimum 3 cycles per transaction; back-to-back throughput is one transaction per 3 cycles.
- Writes: d_ack pulses and d_rdata is unchanged.
- mem_ack in IDLE or RESP is ignored, with no state change.
- i_ack and d_ack are never high in the same cycle. Only the owner's rdata register is updated.
- Reset mid-transaction: returns to IDLE next edge, mem_req=0, no ack is issued, and the transaction is dropped. A late mem_ack after reset is ignored.
- Requester dropping req while in GRANT: the transaction still completes and the ack is still issued.

Optional Feature:
- MEM_ARB_TIMEOUT_EN defined:
  - 8-bit wait counter cleared on entry to GRANT, incremented each GRANT cycle without mem_ack.
  - When the counter reaches TIMEOUT: mem_req=0, go to RESP, and pulse the owner's ack with owner rdata=32'hDEADBEEF (reads only).
  - err pulses in the same cycle as that ack.
  - A mem_ack in the same cycle as the timeout wins: normal completion, no err.
- Undefined: no counter and no err port; GRANT waits indefinitely.

Test Plan:
- Single fetch: i_req=1, i_addr=0x100, mem_ack next cycle with mem_rdata=0x2409002A -> mem_req at cycle 1 with mem_addr=0x100, mem_we=0; i_ack at cycle 2 with i_rdata=0x2409002A; d_ack stays 0.
- Data write: d_req=1, d_we=1, d_addr=0x200, d_wdata=0xCAFEF00D, mem_ack 3-cycle delay -> mem_we=1 and mem_wdata=0xCAFEF00D held stable; d_ack pulses exactly once; d_rdata unchanged.
- Contention: i_req and d_req both held continuously, MAX_D_STREAK=4 -> grant order D,D,D,D,I,D,D,D,D,I; the streak counter resets after each I grant.
- Reset mid-GRANT: reset asserted while mem_req=1, mem_ack arrives the cycle after reset deasserts -> no i_ack/d_ack; state IDLE; all outputs 0.
- Spurious ack: mem_ack=1 while IDLE with no requests -> no ack outputs; rdata registers unchanged.
- Timeout (MEM_ARB_TIMEOUT_EN, TIMEOUT=8): d_req read, mem_ack never asserted -> mem_req drops after 8 GRANT cycles; d_ack and err pulse together; d_rdata=0xDEADBEEF.
